// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types and default widths for the DMA bus-request arbiter.
package dma_bus_arbiter_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 16;
  localparam int unsigned DEFAULT_LEN_W  = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitCpu = 2'd1,
    StGrant   = 2'd2,
    StRelease = 2'd3
  } arb_state_e;

endpackage

// File: rtl/dma_bus_arbiter_intr_latch.sv
// Rising-edge interrupt latch: an edge sets pending, ack clears it, set wins on a tie.
module dma_bus_arbiter_intr_latch (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic ack,
  output logic rise,
  output logic pending
);

  logic src_prev;

  assign rise = src & ~src_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_prev <= 1'b0;
      pending  <= 1'b0;
    end else begin
      src_prev <= src;
      if (rise) begin
        pending <= 1'b1;
      end else if (ack) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// CPU-side DMA responder: command forwarding, bus request/grant arbitration and
// completion interrupt latching.
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
  parameter int unsigned LEN_W      = DEFAULT_LEN_W,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              cmd_ready,
  output logic              dma_start,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [LEN_W-1:0]  dma_len,
  input  logic              br,
  output logic              bg,
  input  logic              cpu_mem_busy,
  output logic              cpu_stall,
  output logic              mem_owner,
  input  logic              dma_intr,
  input  logic              intr_ack,
  output logic              intr_pending,
  output logic [CNT_W-1:0]  grant_count
);

  localparam logic [2:0] TaLast = 3'(TURNAROUND - 1);

  arb_state_e state;
  logic [2:0] ta_cnt;
  logic       dma_busy;
  logic       intr_rise;

  dma_bus_arbiter_intr_latch u_intr_latch (
    .clk     (clk),
    .reset   (reset),
    .src     (dma_intr),
    .ack     (intr_ack),
    .rise    (intr_rise),
    .pending (intr_pending)
  );

  // Combinational so the CPU is held off in the very cycle br appears.
  assign cpu_stall = (state != StIdle) | br;
  assign cmd_ready = ~dma_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_busy  <= 1'b0;
      dma_start <= 1'b0;
      dma_addr  <= '0;
      dma_len   <= '0;
    end else begin
      dma_start <= 1'b0;
      if (cmd_valid && !dma_busy) begin
        dma_busy  <= 1'b1;
        dma_start <= 1'b1;
        dma_addr  <= cmd_addr;
        dma_len   <= cmd_len;
      end else if (intr_rise) begin
        dma_busy <= 1'b0;
      end
    end
  end

  // Grant only issues on an edge where no CPU access is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      bg          <= 1'b0;
      mem_owner   <= 1'b0;
      ta_cnt      <= '0;
      grant_count <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (br && cpu_mem_busy) begin
            state <= StWaitCpu;
          end else if (br) begin
            state     <= StGrant;
            bg        <= 1'b1;
            mem_owner <= 1'b1;
          end
        end
        StWaitCpu: begin
          if (!br) begin
            state <= StIdle;
          end else if (!cpu_mem_busy) begin
            state     <= StGrant;
            bg        <= 1'b1;
            mem_owner <= 1'b1;
          end
        end
        StGrant: begin
          if (!br) begin
            state     <= StRelease;
            bg        <= 1'b0;
            mem_owner <= 1'b0;
            ta_cnt    <= '0;
            if (grant_count != {CNT_W{1'b1}}) begin
              grant_count <= grant_count + 1'b1;
            end
          end
        end
        StRelease: begin
          if (ta_cnt == TaLast) begin
            state <= StIdle;
          end else begin
            ta_cnt <= ta_cnt + 3'd1;
          end
        end
        default: begin
          state     <= StIdle;
          bg        <= 1'b0;
          mem_owner <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
CPU-side responder for the DMA bus-request protocol. It accepts DMA commands from the CPU and forwards them to the DMA engine. It grants the shared memory bus (bg) in answer to the DMA's bus request (br), but only at a safe CPU boundary, and stalls the CPU while the DMA owns the bus. It also latches the DMA completion interrupt until the CPU acknowledges it. It sits between the CPU core, the DMA controller and the memory port mux.

Parameters:
ADDR_W, 16, width of DMA start address
LEN_W, 4, width of DMA data length field
TURNAROUND, 1, idle cycles after bus release before a new grant may issue (1..7)
CNT_W, 16, width of saturating completed-grant counter

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  CPU requests a DMA transfer
cmd_addr  in  ADDR_W  transfer start address
cmd_len  in  LEN_W  transfer length in words
cmd_ready  out  1  arbiter can accept a command
dma_start  out  1  one-cycle pulse to DMA engine
dma_addr  out  ADDR_W  registered address to DMA
dma_len  out  LEN_W  registered length to DMA
br  in  1  DMA bus request (level)
bg  out  1  bus grant to DMA (registered)
cpu_mem_busy  in  1  CPU has a memory access in flight this cycle
cpu_stall  out  1  CPU must not start a new memory access
mem_owner  out  1  0 = CPU drives memory port, 1 = DMA
dma_intr  in  1  DMA completion interrupt (level or pulse)
intr_ack  in  1  CPU acknowledges interrupt
intr_pending  out  1  latched interrupt to CPU
grant_count  out  CNT_W  completed grants, saturating

Behaviour:
- Reset values: bg=0, cpu_stall=0, mem_owner=0, dma_start=0, dma_addr=0, dma_len=0, cmd_ready=1, intr_pending=0, grant_count=0, FSM=IDLE, dma_busy=0.
- An asserted reset forces bg=0 and mem_owner=0 at once, including mid-grant.
- Command path:
  - Handshake when cmd_valid & cmd_ready at a clock edge: dma_addr/dma_len load, dma_start pulses high for the next cycle only, and dma_busy sets.
  - cmd_ready = ~dma_busy.
  - dma_busy clears on the cycle the dma_intr rising edge is detected.
  - Commands offered while busy are ignored; the CPU holds cmd_valid.
- Arbiter FSM (states IDLE, WAIT_CPU, GRANT, RELEASE):
  - IDLE: if br=1 and cpu_mem_busy=0, go to GRANT. If br=1 and cpu_mem_busy=1, go to WAIT_CPU. Otherwise stay.
  - WAIT_CPU: if br=0, go to IDLE (request withdrawn, no grant). If br=1 and cpu_mem_busy=0, go to GRANT. Otherwise stay.
  - GRANT: bg=1, mem_owner=1. Stay while br=1. When br=0, go to RELEASE. bg falls on the first cycle after the br=0 edge.
  - RELEASE: bg=0, mem_owner=0. Count TURNAROUND cycles, ignoring br, then go to IDLE. grant_count increments (saturating at all-ones) on GRANT->RELEASE.
- bg and mem_owner are registered FSM decodes. Latency from br rising (CPU idle) to bg=1 is 1 cycle. Latency from br falling to bg=0 is 1 cycle.
- cpu_stall = (state != IDLE) | (state==IDLE & br). It is combinational, so the CPU is blocked in the same cycle br appears. An access already in flight (cpu_mem_busy) is allowed to complete.
- bg is never 1 while cpu_mem_busy was 1 at the granting edge.
- Interrupt path:
  - dma_intr is edge-detected (registered previous value).
  - A rising edge sets intr_pending; intr_ack clears it.
  - A simultaneous rising edge and ack leaves intr_pending=1 (set wins).
  - A held-high dma_intr does not re-set after ack.
- A br glitch (1-cycle high while CPU busy, then low) yields no bg and no grant_count change.

Decomposition:
- Shared package holds the FSM state enum (IDLE=2'd0, WAIT_CPU=2'd1, GRANT=2'd2, RELEASE=2'd3) and default widths ADDR_W/LEN_W.
- One natural sub-module: intr_latch (edge detect + set/ack with set priority), reusable by other interrupt sources.
- FSM, command register and counter stay in the top module.

Test Plan:
- Reset, then cmd_valid=1, cmd_addr=16'h01F4, cmd_len=4'd12 -> one-cycle dma_start, dma_addr=01F4, dma_len=C, cmd_ready=0 until dma_intr rises.
- br=1 with cpu_mem_busy=0 -> bg=1 and mem_owner=1 next cycle, cpu_stall=1 same cycle. br held 4 cycles then 0 -> bg=0 next cycle, grant_count=1.
- br=1 while cpu_mem_busy=1 for 3 cycles -> bg stays 0 and cpu_stall=1 for those cycles. bg=1 the cycle after cpu_mem_busy falls.
- TURNAROUND=1: br re-asserted the cycle after release -> ignored for 1 cycle, then bg=1. br withdrawn in WAIT_CPU -> FSM back to IDLE, grant_count unchanged.
- dma_intr pulse with intr_ack in the same cycle -> intr_pending=1. Ack next cycle -> 0. dma_intr held high -> stays 0.
- Assert reset during GRANT -> bg=0 and mem_owner=0 immediately. After release, FSM=IDLE, grant_count=0.
